dmem_reader: RTL and testbench
==============================

DMEM_READER -- requirements
Module: dmem_reader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 0, meaning the first data-memory word address read.
REQ-002 The block SHALL have parameter LENGTH, default 129600, meaning the number of words streamed per run (legal range 1..129600).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on posedge clk.
REQ-004 Port rst_n, input, 1 bit: synchronous active-low reset, sampled on posedge clk.
REQ-005 Port start, input, 1 bit: level-sampled request to begin a run.
REQ-006 Port mem_addr, output, 32 bits: word address driven to the data memory's combinational read port.
REQ-007 Port mem_rd, input, 32 bits: read data returned combinationally for mem_addr.
REQ-008 Port px_data, output, 8 bits: streamed pixel byte, mem_rd[7:0] of the addressed word.
REQ-009 Port px_valid, output, 1 bit: px_data holds a valid pixel.
REQ-010 Port px_ready, input, 1 bit: sink accepts px_data this cycle.
REQ-011 Port busy, output, 1 bit: run in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse after the last pixel is accepted.
REQ-013 Port checksum, output, 16 bits: running pixel sum (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, SEND, FINISH.
REQ-015 In IDLE, start=1 SHALL load mem_addr=BASE_ADDR, clear the word counter, and move to FETCH on the next edge; busy=1 from FETCH onward.
REQ-016 In FETCH, mem_addr SHALL be stable for the whole cycle, px_data SHALL capture mem_rd[7:0] at the edge, and the FSM SHALL move to SEND with px_valid=1.
REQ-017 mem_rd[31:8] SHALL be ignored.
REQ-018 In SEND, px_data and px_valid SHALL hold unchanged until px_valid & px_ready are both 1 at an edge.
REQ-019 On that handshake, if counter < LENGTH-1, the block SHALL increment mem_addr and the counter by 1 and move to FETCH with px_valid=0.
REQ-020 On that handshake, if counter == LENGTH-1, the block SHALL move to FINISH.
REQ-021 FINISH SHALL last exactly one cycle with done=1, busy=0, px_valid=0, then return to IDLE.
REQ-022 The first px_valid SHALL assert 2 cycles after start is sampled in IDLE; peak throughput SHALL be one pixel per 2 cycles.
REQ-023 start SHALL be ignored outside IDLE; start held high through FINISH SHALL begin a new run from IDLE on the following cycle.
REQ-024 mem_addr SHALL never exceed BASE_ADDR+LENGTH-1 during a run; the counter SHALL NOT wrap.
REQ-025 For LENGTH=1, exactly one pixel SHALL be emitted, followed by done.

Reset
REQ-026 rst_n=0 at an edge SHALL force state IDLE, with mem_addr=0, counter=0, px_data=0, px_valid=0, busy=0, done=0, checksum=0, from any state including mid-run.
REQ-027 A pixel pending in SEND when reset hits SHALL be dropped without a handshake.

Configuration
REQ-028 With macro DMEM_READER_CHECKSUM_EN defined, checksum SHALL clear when a run starts and add zero-extended px_data, modulo 2^16, on each handshake; it SHALL hold its value after done until the next start.
REQ-029 Without DMEM_READER_CHECKSUM_EN, the checksum port SHALL remain present and be tied to 16'h0000, with no adder logic.

Verification
REQ-030 Basic run: LENGTH=4, mem words 0x11,0x22,0x33,0x44, px_ready=1 constant -> bytes 11,22,33,44 emitted on cycles 2,4,6,8 after start; done on cycle 9; checksum 0x00AA (with macro).
REQ-031 Backpressure: px_ready=0 for 5 cycles during the 2nd pixel -> px_data=0x22 and px_valid held; mem_addr unchanged; no pixel lost or duplicated.
REQ-032 Upper bits ignored: word 0xDEADBE7F -> px_data=0x7F.
REQ-033 Reset mid-run: rst_n=0 during SEND of pixel 3 of 4 -> next cycle IDLE with all outputs 0; no done pulse; a following start restarts at BASE_ADDR.
REQ-034 Boundaries: LENGTH=1 with BASE_ADDR=129599 -> a single pixel from address 129599, then done; start pulses while busy -> no restart.
REQ-035 Macro off: build without DMEM_READER_CHECKSUM_EN and rerun REQ-030 -> checksum=0 throughout, identical pixel stream.

Source files
------------

// File: rtl/dmem_reader.sv
// dmem_reader: streams LENGTH bytes (low byte of each word) from data memory starting at BASE_ADDR.
// Optional running checksum of accepted pixels, enabled by defining DMEM_READER_CHECKSUM_EN.
module dmem_reader #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned LENGTH    = 129600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd,
  output logic [7:0]  px_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 17;
  localparam int unsigned PX_W   = 8;
  localparam int unsigned SUM_W  = 16;

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LENGTH - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PX_W-1:0]   data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              handshake;

  // Only the low byte of each memory word carries pixel data.
  logic [23:0] unused_mem_hi;
  assign unused_mem_hi = mem_rd[31:8];

  assign handshake = valid_q & px_ready;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = BASE;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      FETCH: begin
        data_d  = mem_rd[PX_W-1:0];
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (handshake) begin
          valid_d = 1'b0;
          if (cnt_q == LAST_CNT) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = FETCH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr = addr_q;
  assign px_data  = data_q;
  assign px_valid = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef DMEM_READER_CHECKSUM_EN
  logic [SUM_W-1:0] sum_q, sum_d;

  // Cleared on run start, accumulates each accepted pixel, holds after done.
  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE && start) begin
      sum_d = '0;
    end else if (state_q == SEND && handshake) begin
      sum_d = sum_q + SUM_W'(data_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_reader.sv
// Bench for dmem_reader: per-cycle scoreboard against a stream model plus hand-computed checkpoints.
`timescale 1ns/1ps
module tb_dmem_reader;

  localparam int unsigned BASE4 = 8;
  localparam int unsigned LEN4  = 4;
  localparam int unsigned BASE1 = 129599;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, px_ready, start1, ready1;
  logic [31:0] mem_addr, mem_rd, mem_addr1, mem_rd1;
  logic [7:0]  px_data, px_data1;
  logic        px_valid, px_valid1, busy, busy1, done, done1;
  logic [15:0] checksum, checksum1;
  logic [31:0] mem [16];

  int passed = 0;
  int total  = 0;

  assign mem_rd  = mem[mem_addr[3:0]];
  assign mem_rd1 = (mem_addr1 == 32'(BASE1)) ? 32'hDEADBE7F : 32'h5555_55A0;

  dmem_reader #(.BASE_ADDR(BASE4), .LENGTH(LEN4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready), .busy(busy),
    .done(done), .checksum(checksum)
  );

  dmem_reader #(.BASE_ADDR(BASE1), .LENGTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
    .px_data(px_data1), .px_valid(px_valid1), .px_ready(ready1), .busy(busy1),
    .done(done1), .checksum(checksum1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Stream model: a run is a fetch gap then an offered pixel, repeated LEN4 times, then one done cycle.
  logic       chk_en  = 1'b0;
  logic       m_busy  = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_done  = 1'b0;
  logic       m_rst   = 1'b1;
  int         m_idx   = 0;
  logic [15:0] m_sum  = 16'h0;
  logic [7:0]  exp_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("px_valid", 32'(px_valid), 32'(m_valid));
      check("done", 32'(done), 32'(m_done));
`ifdef DMEM_READER_CHECKSUM_EN
      check("checksum", 32'(checksum), 32'(m_sum));
`else
      check("checksum", 32'(checksum), 32'h0);
`endif
      if (m_busy) check("mem_addr", mem_addr, 32'(BASE4 + m_idx));
      if (m_valid) check("px_data", 32'(px_data),
                         (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hFFFF_FFFF);
      if (m_rst) begin
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_px_data", 32'(px_data), 32'h0);
      end
      m_rst = 1'b0;
      if (!rst_n) begin
        m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_sum = 16'h0; m_idx = 0;
        exp_q.delete();
        m_rst = 1'b1;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_sum = 16'h0; m_idx = 0;
          exp_q.delete();
          for (int i = 0; i < int'(LEN4); i++) exp_q.push_back(mem[4'(BASE4 + i)][7:0]);
        end
      end else if (!m_valid) begin
        m_valid = 1'b1;
      end else if (px_ready) begin
        if (exp_q.size() > 0) begin
          m_sum = m_sum + 16'(exp_q[0]);
          void'(exp_q.pop_front());
        end
        m_valid = 1'b0;
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else begin
          m_idx++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin
      step();
      n++;
    end
    check("done_seen", 32'(done), 32'h1);
  endtask

  logic [10:1] lit_valid;
  logic [10:1] lit_done;
  logic [7:0]  lit_bytes [4];
  logic [15:0] lit_sum;
  logic [15:0] lit_sum1;

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; px_ready = 1'b1; ready1 = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = {24'hC0FFEE, 4'h9, 4'(i)};
    mem[8]  = 32'h1234_5611;
    mem[9]  = 32'hABCD_EF22;
    mem[10] = 32'h0000_0033;
    mem[11] = 32'hFFFF_FF44;
    lit_valid = 10'b0010101010;
    lit_done  = 10'b0100000000;
    lit_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef DMEM_READER_CHECKSUM_EN
    lit_sum  = 16'h00AA;
    lit_sum1 = 16'h007F;
`else
    lit_sum  = 16'h0000;
    lit_sum1 = 16'h0000;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_valid", 32'(px_valid), 32'h0);
    check("rst_checksum", 32'(checksum), 32'h0);
    check("rst1_addr", mem_addr1, 32'h0);
    check("rst1_done", 32'(done1), 32'h0);
    rst_n = 1'b1;

    // Basic run, px_ready held high.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check("run1_valid", 32'(px_valid), 32'(lit_valid[k]));
      check("run1_done", 32'(done), 32'(lit_done[k]));
      if (lit_valid[k]) check("run1_data", 32'(px_data), 32'(lit_bytes[k/2-1]));
      if (k < 10) step();
    end
    check("run1_sum", 32'(checksum), 32'(lit_sum));

    // Backpressure on pixel 2, with start pulses while busy.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    px_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_data", 32'(px_data), 32'h22);
      check("bp_valid", 32'(px_valid), 32'h1);
      check("bp_addr", mem_addr, 32'(BASE4 + 1));
      start = (k % 2 == 1);
      step();
    end
    start = 1'b0;
    px_ready = 1'b1;
    wait_done(20);
    step();
    check("run2_sum", 32'(checksum), 32'(lit_sum));

    // Reset during SEND of pixel 3.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("pre_rst_data", 32'(px_data), 32'h33);
    rst_n = 1'b0;
    step();
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_valid", 32'(px_valid), 32'h0);
    check("mid_rst_addr", mem_addr, 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    repeat (3) step();

    // start held high through FINISH begins a new run from IDLE.
    start = 1'b1;
    step();
    check("run4_base", mem_addr, 32'(BASE4));
    repeat (8) step();
    check("run4_done", 32'(done), 32'h1);
    step();
    check("run4_idle_busy", 32'(busy), 32'h0);
    step();
    check("run4_restart_busy", 32'(busy), 32'h1);
    check("run4_restart_addr", mem_addr, 32'(BASE4));
    start = 1'b0;
    wait_done(20);
    repeat (2) step();

    // LENGTH=1 at the top address; upper bits of the word ignored.
    start1 = 1'b1;
    step();
    check("len1_busy", 32'(busy1), 32'h1);
    check("len1_addr", mem_addr1, 32'(BASE1));
    check("len1_fetch_valid", 32'(px_valid1), 32'h0);
    step();
    check("len1_valid", 32'(px_valid1), 32'h1);
    check("len1_data", 32'(px_data1), 32'h7F);
    step();
    start1 = 1'b0;
    check("len1_done", 32'(done1), 32'h1);
    check("len1_finish_busy", 32'(busy1), 32'h0);
    check("len1_finish_valid", 32'(px_valid1), 32'h0);
    check("len1_sum", 32'(checksum1), 32'(lit_sum1));
    step();
    check("len1_done_pulse", 32'(done1), 32'h0);
    check("len1_no_restart", 32'(busy1), 32'h0);
    step();
    check("len1_still_idle", 32'(busy1), 32'h0);
    check("len1_sum_hold", 32'(checksum1), 32'(lit_sum1));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
